// File: rtl/interval_timer.sv
// Dual-interval timer: independent short/long channels, each with a prescaler to a
// 1 s tick and a seconds counter, returning one-cycle completion pulses.
module interval_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int N_SHORT  = 5,
    parameter int N_LONG   = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en5,
    input  logic       en25,
    input  logic       hold,
    output logic       fin5,
    output logic       fin25,
    output logic [7:0] remain
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0] SHORT_LEN = 8'(N_SHORT);
    localparam logic [7:0] LONG_LEN  = 8'(N_LONG);

    logic [1:0] en_ch;
    logic [1:0] fin_ch;
    logic [7:0] sec_next_ch [2];
    logic [7:0] remain_reg;
    logic [7:0] remain_next;

    assign en_ch = {en25, en5};

    // Channel 0 is the short interval, channel 1 the long one.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            localparam logic [7:0] SEC_LAST = (gi == 0) ? 8'(N_SHORT - 1) : 8'(N_LONG - 1);

            logic [PW-1:0] pre_reg;
            logic [PW-1:0] pre_next;
            logic [7:0]    sec_reg;
            logic [7:0]    sec_next;
            logic          fin_reg;
            logic          fin_next;

            always_comb begin
                pre_next = pre_reg;
                sec_next = sec_reg;
                fin_next = 1'b0;
                if (!en_ch[gi]) begin
                    pre_next = '0;
                    sec_next = '0;
                end else if (hold) begin
                    pre_next = pre_reg;
                    sec_next = sec_reg;
                end else if (pre_reg != PRE_LAST) begin
                    pre_next = pre_reg + 1'b1;
                end else if (sec_reg != SEC_LAST) begin
                    pre_next = '0;
                    sec_next = sec_reg + 8'd1;
                end else begin
                    pre_next = '0;
                    sec_next = '0;
                    fin_next = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    pre_reg <= '0;
                    sec_reg <= '0;
                    fin_reg <= 1'b0;
                end else begin
                    pre_reg <= pre_next;
                    sec_reg <= sec_next;
                    fin_reg <= fin_next;
                end
            end

            assign fin_ch[gi]      = fin_reg;
            assign sec_next_ch[gi] = sec_next;
        end
    endgenerate

    // Display follows the long channel whenever it is active, using next-state counts
    // so the value lines up with the registered fin pulse.
    always_comb begin
        remain_next = 8'd0;
        if (en25)
            remain_next = LONG_LEN - sec_next_ch[1];
        else if (en5)
            remain_next = SHORT_LEN - sec_next_ch[0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            remain_reg <= 8'd0;
        else
            remain_reg <= remain_next;
    end

    assign fin5   = fin_ch[0];
    assign fin25  = fin_ch[1];
    assign remain = remain_reg;
endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: stimulus queues expected fin events, a monitor
// pops and compares them whenever a fin pulse appears.
module tb_interval_timer;
    localparam int TICK_DIV = 4;
    localparam int N_SHORT  = 5;
    localparam int N_LONG   = 25;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en5 = 1'b0;
    logic       en25 = 1'b0;
    logic       hold = 1'b0;
    logic       fin5;
    logic       fin25;
    logic [7:0] remain;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int   cyc;
        logic f5;
        logic f25;
        int   rem;
    } exp_t;
    exp_t q[$];

    interval_timer #(.TICK_DIV(TICK_DIV), .N_SHORT(N_SHORT), .N_LONG(N_LONG)) dut (
        .clk(clk), .rst(rst), .en5(en5), .en25(en25), .hold(hold),
        .fin5(fin5), .fin25(fin25), .remain(remain)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int c, input logic f5, input logic f25, input int rem);
        exp_t e;
        e.cyc = c; e.f5 = f5; e.f25 = f25; e.rem = rem;
        q.push_back(e);
    endtask

    // Monitor: every fin pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && (fin5 || fin25)) begin
            if (q.size() == 0) begin
                chk("unexpected_fin", {30'd0, fin25, fin5}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("fin_cycle", cyc, e.cyc);
                chk("fin5", int'(fin5), int'(e.f5));
                chk("fin25", int'(fin25), int'(e.f25));
                chk("fin_remain", int'(remain), e.rem);
                $display("txn fin cyc=%0d fin5=%0b fin25=%0b remain=%0d", cyc, fin5, fin25, remain);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        // Reset state
        step(2);
        chk("rst_fin5", int'(fin5), 0);
        chk("rst_fin25", int'(fin25), 0);
        chk("rst_remain", int'(remain), 0);

        // Short interval, remain countdown
        rst = 1'b0; en5 = 1'b1; c = cyc;
        push(c + 20, 1'b1, 1'b0, 5);
        for (int k = 1; k <= 19; k++) begin
            step(1);
            chk("short_remain", int'(remain), 5 - k / 4);
        end
        step(2);
        en5 = 1'b0;
        step(3);
        chk("short_idle_remain", int'(remain), 0);

        // Long interval, en held one extra cycle after fin
        en25 = 1'b1; c = cyc;
        push(c + 100, 1'b0, 1'b1, 25);
        step(101);
        en25 = 1'b0;
        step(3);
        chk("long_idle_remain", int'(remain), 0);

        // Abort mid-count discards progress
        en5 = 1'b1; c = cyc;
        step(10);
        en5 = 1'b0;
        step(1);
        en5 = 1'b1;
        push(c + 31, 1'b1, 1'b0, 5);
        step(21);
        en5 = 1'b0;
        step(3);

        // Hold for 7 cycles mid-count delays fin25 by 7
        en25 = 1'b1; c = cyc;
        push(c + 107, 1'b0, 1'b1, 25);
        step(30);
        chk("pre_hold_remain", int'(remain), 18);
        hold = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step(1);
            chk("hold_remain", int'(remain), 18);
            chk("hold_fin25", int'(fin25), 0);
        end
        hold = 1'b0;
        step(71);
        en25 = 1'b0;
        step(3);

        // Both channels together
        en5 = 1'b1; en25 = 1'b1; c = cyc;
        push(c + 20, 1'b1, 1'b0, 20);
        push(c + 40, 1'b1, 1'b0, 15);
        push(c + 60, 1'b1, 1'b0, 10);
        push(c + 80, 1'b1, 1'b0, 5);
        push(c + 100, 1'b1, 1'b1, 25);
        step(101);
        en5 = 1'b0; en25 = 1'b0;
        step(3);

        // Reset mid-run restarts the long count
        en25 = 1'b1; c = cyc;
        step(50);
        rst = 1'b1;
        step(1);
        chk("midrst_fin5", int'(fin5), 0);
        chk("midrst_fin25", int'(fin25), 0);
        chk("midrst_remain", int'(remain), 0);
        rst = 1'b0;
        push(c + 151, 1'b0, 1'b1, 25);
        step(101);
        en25 = 1'b0;
        step(5);

        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
